// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: state encoding and default widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int RD_W_DEF   = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating accumulator: adds add_i every cycle and sticks at all-ones.
module pipe_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] add_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W:0]   sum;

   assign sum   = {1'b0, cnt_q} + {1'b0, add_i};
   assign cnt_o = cnt_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         cnt_q <= '0;
      else if (sum[CNT_W])
         cnt_q <= '1;
      else
         cnt_q <= sum[CNT_W-1:0];
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to build the stall/flush performance counters.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NUM_LANES = 2,
   parameter int CTRL_W    = 2,
   parameter int RD_W      = RD_W_DEF,
   parameter int CNT_W     = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   input  logic [NUM_LANES*DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0]           in_ctrl_i,
   input  logic [RD_W-1:0]             in_rd_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [NUM_LANES*DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0]           out_ctrl_o,
   output logic [RD_W-1:0]             out_rd_o,
   output logic [CNT_W-1:0]            stall_cnt_o,
   output logic [CNT_W-1:0]            flush_cnt_o
);

   localparam int PL_W = NUM_LANES*DATA_W + CTRL_W + RD_W;

   stage_state_e    state_q;
   logic            in_ready_q;
   logic [PL_W-1:0] main_q, skid_q, in_pl;
   logic            main_valid, skid_valid, accept, drain;

   assign in_pl      = {in_data_i, in_ctrl_i, in_rd_i};
   assign main_valid = (state_q != EMPTY);
   assign skid_valid = (state_q == FULL);
   assign accept     = in_valid_i && in_ready_q;
   assign drain      = main_valid && out_ready_i;

   // in_ready is its own flop so downstream ready never reaches it combinationally
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush_i) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         case (state_q)
            EMPTY: if (accept) begin
               main_q  <= in_pl;
               state_q <= ONE;
            end
            ONE: begin
               if (accept && drain) begin
                  main_q <= in_pl;
               end else if (accept) begin
                  skid_q     <= in_pl;
                  state_q    <= FULL;
                  in_ready_q <= 1'b0;
               end else if (drain) begin
                  state_q <= EMPTY;
               end
            end
            FULL: if (drain) begin
               main_q     <= skid_q;
               state_q    <= ONE;
               in_ready_q <= 1'b1;
            end
            default: begin
               state_q    <= EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = main_valid;
   assign out_data_o  = main_q[PL_W-1 -: NUM_LANES*DATA_W];
   assign out_ctrl_o  = main_valid ? main_q[RD_W +: CTRL_W] : '0;
   assign out_rd_o    = main_q[RD_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_add, flush_add;

   assign stall_add = CNT_W'(main_valid && !out_ready_i);
   assign flush_add = flush_i ? CNT_W'({1'b0, main_valid} + {1'b0, skid_valid}) : '0;

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .add_i (stall_add),
      .cnt_o (stall_cnt_o)
   );

   pipe_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .add_i (flush_add),
      .cnt_o (flush_cnt_o)
   );
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule
